// File: rtl/hitomezashi_pattern_gen.sv
// hitomezashi_pattern_gen
// Two-stage Hitomezashi stitch-pattern generator between the video timing
// generator and the TMDS encoder. Row/column bitstreams are loaded through a
// valid/ready port into shadow registers and committed only on framestart,
// so a frame never shows a mixed pattern.
// Optional feature macro: HITOMEZASHI_ANIM_EN -- per-frame rotation of the
// active bitstreams every FRAMES_PER_STEP frames.
module hitomezashi_pattern_gen #(
  parameter int                          WIDTH           = 1280,
  parameter int                          HEIGHT          = 720,
  parameter int                          CELL_LOG2       = 4,
  parameter int                          BITS_LOG2       = 3,
  parameter int                          LINE_W          = 2,
  parameter logic [(1<<BITS_LOG2)-1:0]   ROW_INIT        = 8'hCC,
  parameter logic [(1<<BITS_LOG2)-1:0]   COL_INIT        = 8'h33,
  parameter logic [23:0]                 FG_RGB          = 24'hFF0000,
  parameter logic [23:0]                 BG_RGB          = 24'h000000,
  parameter int                          FRAMES_PER_STEP = 4
) (
  input  logic                           pix_clk,
  input  logic                           rst,
  input  logic                           framestart,
  input  logic signed [15:0]             i_x,
  input  logic signed [15:0]             i_y,
  input  logic                           ld_valid,
  input  logic                           ld_sel,
  input  logic [(1<<BITS_LOG2)-1:0]      ld_data,
  output logic                           ld_ready,
  output logic [7:0]                     o_red,
  output logic [7:0]                     o_green,
  output logic [7:0]                     o_blue
);

  localparam int N = 1 << BITS_LOG2;
  localparam logic signed [15:0] WIDTH_S  = 16'(WIDTH);
  localparam logic signed [15:0] HEIGHT_S = 16'(HEIGHT);
  // One extra bit so LINE_W may equal the full cell edge.
  localparam logic [CELL_LOG2:0] LINE_LIM = (CELL_LOG2+1)'(LINE_W);

  function automatic logic [N-1:0] rot_left(input logic [N-1:0] b);
    return {b[N-2:0], b[N-1]};
  endfunction

  function automatic logic [N-1:0] rot_right(input logic [N-1:0] b);
    return {b[0], b[N-1:1]};
  endfunction

  function automatic logic [23:0] pick_rgb(input logic act, input logic stitch);
    if (!act)
      return 24'h000000;
    else if (stitch)
      return FG_RGB;
    else
      return BG_RGB;
  endfunction

  logic [N-1:0] row_act;
  logic [N-1:0] col_act;
  logic [N-1:0] row_shd;
  logic [N-1:0] col_shd;
  logic [1:0]   pend;
  logic         accept;
  logic         step;

  assign ld_ready = ~pend[ld_sel];
  assign accept   = ld_valid & ~pend[ld_sel];

`ifdef HITOMEZASHI_ANIM_EN
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic [CNT_W-1:0] frame_cnt;

  assign step = framestart && (frame_cnt == CNT_LAST);

  // Frame counter: advances once per frame and wraps on the step frame.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (framestart)
      frame_cnt <= step ? '0 : frame_cnt + 1'b1;
  end
`else
  assign step = 1'b0;
`endif

  // Load port, shadow capture and frame-start commit; a commit beats a rotation.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      pend    <= 2'b00;
      row_shd <= ROW_INIT;
      col_shd <= COL_INIT;
      row_act <= ROW_INIT;
      col_act <= COL_INIT;
    end else begin
      if (accept && !ld_sel)
        row_shd <= ld_data;
      if (accept && ld_sel)
        col_shd <= ld_data;

      if (framestart && pend[0])
        row_act <= row_shd;
      else if (step)
        row_act <= rot_left(row_act);

      if (framestart && pend[1])
        col_act <= col_shd;
      else if (step)
        col_act <= rot_right(col_act);

      // A word accepted on the framestart cycle stays pending for the next frame.
      if (accept && !ld_sel)
        pend[0] <= 1'b1;
      else if (framestart)
        pend[0] <= 1'b0;

      if (accept && ld_sel)
        pend[1] <= 1'b1;
      else if (framestart)
        pend[1] <= 1'b0;
    end
  end

  // ---- stage 1: cell index, in-cell offset, active-area flag ----
  logic                 act_p1;
  logic [BITS_LOG2-1:0] cxi_p1;
  logic [BITS_LOG2-1:0] cyi_p1;
  logic [CELL_LOG2-1:0] ox_p1;
  logic [CELL_LOG2-1:0] oy_p1;

  // Active-area flag is control and is cleared by reset.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst)
      act_p1 <= 1'b0;
    else
      act_p1 <= (i_x >= 16'sd0) && (i_x < WIDTH_S) &&
                (i_y >= 16'sd0) && (i_y < HEIGHT_S);
  end

  // Cell index mod N and offset are plain bit slices of the coordinates.
  always_ff @(posedge pix_clk) begin
    cxi_p1 <= i_x[CELL_LOG2+BITS_LOG2-1:CELL_LOG2];
    cyi_p1 <= i_y[CELL_LOG2+BITS_LOG2-1:CELL_LOG2];
    ox_p1  <= i_x[CELL_LOG2-1:0];
    oy_p1  <= i_y[CELL_LOG2-1:0];
  end

  // ---- stage 2: stitch decision and colour ----
  logic        h_p1;
  logic        v_p1;
  logic [23:0] rgb_p2;

  assign h_p1 = ({1'b0, oy_p1} < LINE_LIM) && ((cxi_p1[0] ^ row_act[cyi_p1]) == 1'b0);
  assign v_p1 = ({1'b0, ox_p1} < LINE_LIM) && ((cyi_p1[0] ^ col_act[cxi_p1]) == 1'b0);

  // Registered pixel colour; off-screen pixels are forced to black.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst)
      rgb_p2 <= 24'h000000;
    else
      rgb_p2 <= pick_rgb(act_p1, h_p1 || v_p1);
  end

  assign o_red   = rgb_p2[23:16];
  assign o_green = rgb_p2[15:8];
  assign o_blue  = rgb_p2[7:0];

endmodule

// File: tb/tb_hitomezashi_pattern_gen.sv
// Directed bench for hitomezashi_pattern_gen with default parameters
// (row CC, column 33, 16-pixel cells, 2-pixel stitches, red on black).
module tb_hitomezashi_pattern_gen;

  logic              pix_clk = 1'b0;
  logic              rst;
  logic              framestart;
  logic signed [15:0] i_x;
  logic signed [15:0] i_y;
  logic              ld_valid;
  logic              ld_sel;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic [7:0]        o_red;
  logic [7:0]        o_green;
  logic [7:0]        o_blue;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] BLK = 24'h000000;

  always #5 pix_clk = ~pix_clk;

  hitomezashi_pattern_gen dut (
    .pix_clk    (pix_clk),
    .rst        (rst),
    .framestart (framestart),
    .i_x        (i_x),
    .i_y        (i_y),
    .ld_valid   (ld_valid),
    .ld_sel     (ld_sel),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .o_red      (o_red),
    .o_green    (o_green),
    .o_blue     (o_blue)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present a coordinate, then check the colour two clock edges later.
  task automatic pix(input string tag, input int x, input int y, input logic [23:0] exp);
    @(negedge pix_clk);
    i_x = 16'(x);
    i_y = 16'(y);
    @(posedge pix_clk);
    @(posedge pix_clk);
    #1;
    check(tag, {8'h00, o_red, o_green, o_blue}, {8'h00, exp});
  endtask

  task automatic pulse_fs();
    @(negedge pix_clk);
    framestart = 1'b1;
    @(negedge pix_clk);
    framestart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge pix_clk);
    rst = 1'b1;
    repeat (3) @(negedge pix_clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; framestart = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_data = 8'h00;
    i_x = 16'sd0; i_y = 16'sd0;

    // Reset state: (0,0) would be red if the pipeline ran.
    repeat (3) @(posedge pix_clk);
    #1;
    check("rst_rgb", {8'h00, o_red, o_green, o_blue}, {8'h00, BLK});
    check("rst_ready", {31'd0, ld_ready}, 32'd1);
    @(negedge pix_clk);
    rst = 1'b0;

    // Default pattern.
    pix("p0_0",    0,    0, RED);
    pix("p16_0",   16,   0, BLK);
    pix("p16_16",  16,  16, RED);
    pix("p8_8",    8,    8, BLK);
    pix("p0_1",    0,    1, RED);
    pix("p0_2",    0,    2, BLK);
    pix("p1248",   1248, 704, RED);
    pix("neg_x",   -1,   5, BLK);
    pix("x_over",  1280, 0, BLK);
    pix("y_over",  0,  720, BLK);

    // Exact two-cycle latency.
    pix("lat_pre", 16, 0, BLK);
    @(negedge pix_clk);
    i_x = 16'sd0; i_y = 16'sd0;
    @(posedge pix_clk); #1;
    check("lat_1", {8'h00, o_red, o_green, o_blue}, {8'h00, BLK});
    @(posedge pix_clk); #1;
    check("lat_2", {8'h00, o_red, o_green, o_blue}, {8'h00, RED});

    // Four frame starts: rotation only when the animation is built in.
    repeat (3) pulse_fs();
    pix("anim3_0_0", 0, 0, RED);
    pulse_fs();
`ifdef HITOMEZASHI_ANIM_EN
    pix("anim4_0_0",  0, 0, BLK);
    pix("anim4_16_0", 16, 0, RED);
`else
    pix("anim4_0_0",  0, 0, RED);
    pix("anim4_16_0", 16, 0, BLK);
`endif
    do_reset();

    // Row load mid-frame, held valid while pending, concurrent column load.
    @(negedge pix_clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 8'h01;
    #1;
    check("rdy_row_idle", {31'd0, ld_ready}, 32'd1);
    @(posedge pix_clk); #1;
    check("rdy_row_drop", {31'd0, ld_ready}, 32'd0);
    ld_data = 8'hFF;
    @(posedge pix_clk); #1;
    check("rdy_row_held", {31'd0, ld_ready}, 32'd0);
    ld_sel = 1'b1; ld_data = 8'h01;
    #1;
    check("rdy_col_idle", {31'd0, ld_ready}, 32'd1);
    @(posedge pix_clk); #1;
    ld_valid = 1'b0;
    check("rdy_col_drop", {31'd0, ld_ready}, 32'd0);
    pix("pend_0_0",   0,  0, RED);
    pix("pend_16_16", 16, 16, RED);
    pulse_fs();
    ld_sel = 1'b0; #1;
    check("rdy_row_back", {31'd0, ld_ready}, 32'd1);
    ld_sel = 1'b1; #1;
    check("rdy_col_back", {31'd0, ld_ready}, 32'd1);
    pix("cmt_0_0",   0,  0, BLK);
    pix("cmt_16_16", 16, 16, BLK);
    pix("cmt_16_0",  16,  0, RED);

    // Accept on the framestart cycle: stays pending until the next one.
    @(negedge pix_clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 8'hCC; framestart = 1'b1;
    @(negedge pix_clk);
    ld_valid = 1'b0; framestart = 1'b0;
    #1;
    check("same_fs_rdy", {31'd0, ld_ready}, 32'd0);
    pix("same_fs_0_0", 0, 0, BLK);
    pulse_fs();
    check("next_fs_rdy", {31'd0, ld_ready}, 32'd1);
    pix("next_fs_0_0", 0, 0, RED);

    // Reset two cycles after an accept discards the pending word.
    @(negedge pix_clk);
    ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 8'h01;
    @(negedge pix_clk);
    ld_valid = 1'b0;
    @(posedge pix_clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_rgb", {8'h00, o_red, o_green, o_blue}, {8'h00, BLK});
    check("rst_async_rdy", {31'd0, ld_ready}, 32'd1);
    repeat (2) @(negedge pix_clk);
    rst = 1'b0;
    pulse_fs();
    pix("rst_0_0",   0,  0, RED);
    pix("rst_16_16", 16, 16, RED);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
